// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: byte-write masks,
// arbiter state encodings, owner codes and small helpers.
package mem_port_arbiter_pkg;

    // Byte-write masks as produced by the control unit
    localparam logic [3:0] MEM_READ    = 4'b0000;
    localparam logic [3:0] MEM_WRITE_B = 4'b0001;
    localparam logic [3:0] MEM_WRITE_H = 4'b0011;
    localparam logic [3:0] MEM_WRITE_W = 4'b1111;

    // Transaction owner codes
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    // Width of the starvation counter
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_WAIT_IF = 2'b01,
        ARB_WAIT_LS = 2'b10
    } arb_state_t;

    // True for the two states that hold a memory request open
    function automatic logic is_wait_state(input arb_state_t s);
        return (s == ARB_WAIT_IF) || (s == ARB_WAIT_LS);
    endfunction

    // True when the mask describes a store of any size
    function automatic logic is_write(input logic [3:0] wstrb);
        return (wstrb != MEM_READ);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating starvation counter: counts consecutive LS grants taken while
// IF was waiting, and flags when IF must be served next.
module arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             at_max_r;

    // Next count: clear wins over increment, increment saturates at MAX
    always_comb begin
        cnt_s = cnt_r;
        if (clr) begin
            cnt_s = '0;
        end else if (inc && (cnt_r < MAX_C)) begin
            cnt_s = cnt_r + ONE_C;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Count register plus a registered copy of the saturation flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            at_max_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_s;
            at_max_r <= (cnt_s == MAX_C);
        end
    end

    assign at_max = at_max_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. One transaction outstanding at a time; LS has priority, with
// a starvation counter forcing an IF grant after STARVE_MAX LS wins.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ls_req_valid,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [3:0]        ls_req_wstrb,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    arb_state_t        state_r;
    arb_state_t        state_s;
    logic              if_grant_s;
    logic              ls_grant_s;
    logic              starve_inc_s;
    logic              starve_clr_s;
    logic              starve_at_max_s;
    logic              idle_s;

    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        mem_wstrb_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              busy_r;
    logic              owner_r;
    logic              if_rsp_valid_r;
    logic [DATA_W-1:0] if_rsp_data_r;
    logic              ls_rsp_valid_r;
    logic [DATA_W-1:0] ls_rsp_data_r;

    assign idle_s = (state_r == ARB_IDLE);

    arb_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc_s),
        .clr   (starve_clr_s),
        .at_max(starve_at_max_s)
    );

    // Same-cycle arbitration in IDLE: LS first unless IF has been starved
    always_comb begin
        if_grant_s = 1'b0;
        ls_grant_s = 1'b0;
        if (idle_s) begin
            if (ls_req_valid && if_req_valid) begin
                if (starve_at_max_s) begin
                    if_grant_s = 1'b1;
                end else begin
                    ls_grant_s = 1'b1;
                end
            end else if (ls_req_valid) begin
                ls_grant_s = 1'b1;
            end else if (if_req_valid) begin
                if_grant_s = 1'b1;
            end else begin
                if_grant_s = 1'b0;
                ls_grant_s = 1'b0;
            end
        end else begin
            if_grant_s = 1'b0;
            ls_grant_s = 1'b0;
        end
    end

    // Starvation bookkeeping: count LS wins over a waiting IF, clear otherwise
    always_comb begin
        starve_inc_s = 1'b0;
        starve_clr_s = 1'b0;
        if (idle_s) begin
            starve_inc_s = ls_grant_s & if_req_valid;
            starve_clr_s = if_grant_s | ~if_req_valid;
        end else begin
            starve_inc_s = 1'b0;
            starve_clr_s = 1'b0;
        end
    end

    // Next-state logic: accept moves to a wait state, mem_ack returns to IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (ls_grant_s) begin
                    state_s = ARB_WAIT_LS;
                end else if (if_grant_s) begin
                    state_s = ARB_WAIT_IF;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_WAIT_IF, ARB_WAIT_LS: begin
                if (mem_ack) begin
                    state_s = ARB_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ARB_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Memory-side registers: request flag, busy/owner and captured request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_r   <= 1'b0;
            busy_r      <= 1'b0;
            owner_r     <= OWNER_IF;
            mem_addr_r  <= '0;
            mem_wstrb_r <= MEM_READ;
            mem_wdata_r <= '0;
        end else begin
            mem_req_r <= is_wait_state(state_s);
            busy_r    <= (state_s != ARB_IDLE);
            if (ls_grant_s) begin
                owner_r     <= OWNER_LS;
                mem_addr_r  <= ls_req_addr;
                mem_wstrb_r <= ls_req_wstrb;
                mem_wdata_r <= is_write(ls_req_wstrb) ? ls_req_wdata : ls_req_wdata;
            end else if (if_grant_s) begin
                owner_r     <= OWNER_IF;
                mem_addr_r  <= if_req_addr;
                mem_wstrb_r <= MEM_READ;
                mem_wdata_r <= '0;
            end else begin
                owner_r     <= owner_r;
                mem_addr_r  <= mem_addr_r;
                mem_wstrb_r <= mem_wstrb_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Response capture: one-cycle pulse, data held until next own capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_rsp_valid_r <= 1'b0;
            ls_rsp_valid_r <= 1'b0;
            if_rsp_data_r  <= '0;
            ls_rsp_data_r  <= '0;
        end else begin
            if_rsp_valid_r <= (state_r == ARB_WAIT_IF) && mem_ack;
            ls_rsp_valid_r <= (state_r == ARB_WAIT_LS) && mem_ack;
            if ((state_r == ARB_WAIT_IF) && mem_ack) begin
                if_rsp_data_r <= mem_rdata;
            end else begin
                if_rsp_data_r <= if_rsp_data_r;
            end
            if ((state_r == ARB_WAIT_LS) && mem_ack) begin
                ls_rsp_data_r <= mem_rdata;
            end else begin
                ls_rsp_data_r <= ls_rsp_data_r;
            end
        end
    end

    assign if_req_ready = if_grant_s;
    assign ls_req_ready = ls_grant_s;
    assign if_rsp_valid = if_rsp_valid_r;
    assign if_rsp_data  = if_rsp_data_r;
    assign ls_rsp_valid = ls_rsp_valid_r;
    assign ls_rsp_data  = ls_rsp_data_r;
    assign mem_req      = mem_req_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wstrb    = mem_wstrb_r;
    assign mem_wdata    = mem_wdata_r;
    assign busy         = busy_r;
    assign owner        = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int SMAX = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = 32'd0;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid = 1'b0;
    logic [31:0] ls_req_addr = 32'd0;
    logic [3:0]  ls_req_wstrb = 4'd0;
    logic [31:0] ls_req_wdata = 32'd0;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy;
    logic        owner;

    logic        resp_ack = 1'b0;
    logic        spur_ack = 1'b0;
    assign mem_ack = resp_ack | spur_ack;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wstrb(ls_req_wstrb),
        .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory responder ----------------
    int  fixed_lat = -1;
    int  cur_lat = 0;
    int  wait_cnt = 0;
    bit  force_rdata_en = 1'b0;
    logic [31:0] force_rdata = 32'd0;

    always @(posedge clk) begin
        #1;
        if (!rst_n || !mem_req) begin
            resp_ack = 1'b0;
            wait_cnt = 0;
        end else begin
            if (wait_cnt == 0) cur_lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
            if (wait_cnt >= cur_lat) begin
                resp_ack  = 1'b1;
                mem_rdata = force_rdata_en ? force_rdata : $urandom();
            end else begin
                wait_cnt++;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        own;
    } txn_t;
    typedef struct {
        logic        own;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    txn_t txn_q[$];
    rsp_t rsp_q[$];
    bit   m_busy = 1'b0;
    int   m_starve = 0;
    logic exp_if_g, exp_ls_g;
    txn_t t_new;
    rsp_t r_new;

    // Model: decides grants from the priority/starvation rule, tracks the
    // single outstanding transaction and queues the expected responses.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_starve = 0;
            txn_q.delete();
            rsp_q.delete();
        end else begin
            exp_if_g = 1'b0;
            exp_ls_g = 1'b0;
            if (!m_busy) begin
                if (ls_req_valid && if_req_valid) begin
                    if (m_starve >= SMAX) exp_if_g = 1'b1; else exp_ls_g = 1'b1;
                end else if (ls_req_valid) exp_ls_g = 1'b1;
                else if (if_req_valid) exp_if_g = 1'b1;
            end
            chk("if_req_ready", if_req_ready, exp_if_g);
            chk("ls_req_ready", ls_req_ready, exp_ls_g);
            chk("busy", busy, m_busy);
            chk("mem_req", mem_req, m_busy);
            if (m_busy) begin
                if (txn_q.size() == 0) begin
                    chk("txn_expected", 1'b0, 1'b1);
                end else begin
                    chk("mem_addr", mem_addr, txn_q[0].addr);
                    chk("mem_wstrb", mem_wstrb, txn_q[0].wstrb);
                    chk("mem_wdata", mem_wdata, txn_q[0].wdata);
                    chk("owner", owner, txn_q[0].own);
                    if (mem_ack) begin
                        r_new.own  = txn_q[0].own;
                        r_new.data = mem_rdata;
                        r_new.cyc  = cyc;
                        rsp_q.push_back(r_new);
                        void'(txn_q.pop_front());
                        m_busy = 1'b0;
                    end
                end
            end else begin
                if (exp_ls_g && if_req_valid) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
                else if (exp_if_g || !if_req_valid) m_starve = 0;
                if (exp_if_g || exp_ls_g) begin
                    t_new.own   = exp_ls_g;
                    t_new.addr  = exp_ls_g ? ls_req_addr : if_req_addr;
                    t_new.wstrb = exp_ls_g ? ls_req_wstrb : 4'b0000;
                    t_new.wdata = exp_ls_g ? ls_req_wdata : 32'd0;
                    txn_q.push_back(t_new);
                    m_busy = 1'b1;
                end
            end
        end
    end

    logic [31:0] last_if = 32'd0;
    logic [31:0] last_ls = 32'd0;
    rsp_t        r_pop;

    // Response monitor: pops the scoreboard whenever the DUT pulses a response
    always @(negedge clk) begin
        if (!rst_n) begin
            last_if = 32'd0;
            last_ls = 32'd0;
        end else begin
            if (if_rsp_valid && ls_rsp_valid) chk("rsp_both", 1'b1, 1'b0);
            if (if_rsp_valid || ls_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b00);
                end else begin
                    r_pop = rsp_q.pop_front();
                    chk("rsp_owner", ls_rsp_valid, r_pop.own);
                    chk("rsp_cycle", cyc, r_pop.cyc + 1);
                    if (r_pop.own) begin
                        chk("ls_rsp_data", ls_rsp_data, r_pop.data);
                        last_ls = r_pop.data;
                    end else begin
                        chk("if_rsp_data", if_rsp_data, r_pop.data);
                        last_if = r_pop.data;
                    end
                end
            end
            if (!if_rsp_valid) chk("if_rsp_hold", if_rsp_data, last_if);
            if (!ls_rsp_valid) chk("ls_rsp_hold", ls_rsp_data, last_ls);
        end
    end

    // ---------------- stimulus ----------------
    bit if_taken = 1'b0;
    bit ls_taken = 1'b0;

    task automatic tick();
        @(negedge clk);
        if_taken = if_req_valid && if_req_ready;
        ls_taken = ls_req_valid && ls_req_ready;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] wstrb_tab [9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    bit exp_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int prev;
        int pct;

        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rsp", {if_rsp_valid, if_rsp_data}, 33'd0);
        chk("rst_ls_rsp", {ls_rsp_valid, ls_rsp_data}, 33'd0);
        rst_n = 1'b1;
        tick();

        // 1: single fetch, ack two cycles after mem_req
        fixed_lat = 2; force_rdata_en = 1'b1; force_rdata = 32'h00500093;
        if_req_valid = 1'b1; if_req_addr = 32'h100;
        n = 0; do begin tick(); n++; end while (!if_taken && n < 20);
        chk("t1_accept", if_taken, 1'b1);
        if_req_valid = 1'b0;
        n = 0; while (!if_rsp_valid && n < 20) begin tick(); n++; end
        chk("t1_rsp_seen", if_rsp_valid, 1'b1);
        chk("t1_data", if_rsp_data, 32'h00500093);
        tick();
        chk("t1_pulse_len", if_rsp_valid, 1'b0);
        force_rdata_en = 1'b0;
        tick();

        // 2: both requesters always valid, grant order LS,LS,IF,LS,LS,IF
        fixed_lat = 0;
        if_req_valid = 1'b1; if_req_addr = $urandom() & 32'hFFFF_FFFC;
        ls_req_valid = 1'b1; ls_req_addr = $urandom(); ls_req_wstrb = 4'b0000; ls_req_wdata = $urandom();
        for (int g = 0; g < 6; g++) begin
            n = 0; do begin tick(); n++; end while (!if_taken && !ls_taken && n < 20);
            chk("t2_grant_seen", if_taken | ls_taken, 1'b1);
            chk("t2_grant_order", ls_taken, exp_pat[g]);
            if (if_taken) if_req_addr = $urandom() & 32'hFFFF_FFFC;
            if (ls_taken) ls_req_addr = $urandom();
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        repeat (4) tick();

        // 3: LS halfword store held until ack
        fixed_lat = 3;
        ls_req_valid = 1'b1; ls_req_addr = 32'h20; ls_req_wstrb = 4'b0011; ls_req_wdata = 32'h0000BEEF;
        n = 0; do begin tick(); n++; end while (!ls_taken && n < 20);
        chk("t3_accept", ls_taken, 1'b1);
        ls_req_valid = 1'b0;
        n = 0;
        while (!ls_rsp_valid && n < 20) begin
            if (mem_req) begin
                chk("t3_mem_wstrb", mem_wstrb, 4'b0011);
                chk("t3_mem_wdata", mem_wdata, 32'h0000BEEF);
            end
            chk("t3_no_if_rsp", if_rsp_valid, 1'b0);
            tick(); n++;
        end
        chk("t3_ls_rsp", ls_rsp_valid, 1'b1);
        chk("t3_no_if_rsp_end", if_rsp_valid, 1'b0);
        repeat (2) tick();

        // 4: zero-wait memory, fetch streaming -> one accept every 2 cycles
        fixed_lat = 0;
        if_req_valid = 1'b1; if_req_addr = 32'h400;
        prev = 0;
        for (int g = 0; g < 6; g++) begin
            n = 0; do begin tick(); n++; end while (!if_taken && n < 20);
            chk("t4_accept", if_taken, 1'b1);
            if (g > 0) chk("t4_accept_gap", cyc - prev, 2);
            prev = cyc;
            if_req_addr = if_req_addr + 32'd4;
        end
        if_req_valid = 1'b0;
        repeat (4) tick();

        // 5: reset while waiting on an LS load, late ack afterwards
        fixed_lat = 100;
        ls_req_valid = 1'b1; ls_req_addr = 32'h80; ls_req_wstrb = 4'b0000;
        n = 0; do begin tick(); n++; end while (!ls_taken && n < 20);
        chk("t5_accept", ls_taken, 1'b1);
        ls_req_valid = 1'b0;
        repeat (2) tick();
        chk("t5_waiting", mem_req, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_mem_req", mem_req, 1'b0);
        chk("t5_busy", busy, 1'b0);
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        chk("t5_no_ls_rsp", ls_rsp_valid, 1'b0);
        tick();
        chk("t5_no_ls_rsp2", ls_rsp_valid, 1'b0);
        chk("t5_idle", busy, 1'b0);
        fixed_lat = -1;

        // 6: spurious ack while idle
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        chk("t6_no_if_rsp", if_rsp_valid, 1'b0);
        chk("t6_no_ls_rsp", ls_rsp_valid, 1'b0);
        tick();
        chk("t6_busy", busy, 1'b0);
        chk("t6_mem_req", mem_req, 1'b0);

        // Randomized traffic with random memory latency
        for (int i = 0; i < 800; i++) begin
            pct = (i < 400) ? 40 : 85;
            if (!if_req_valid || if_taken) begin
                if_req_valid = ($urandom_range(0, 99) < pct);
                if_req_addr  = $urandom() & 32'hFFFF_FFFC;
            end
            if (!ls_req_valid || ls_taken) begin
                ls_req_valid = ($urandom_range(0, 99) < pct);
                ls_req_addr  = $urandom();
                ls_req_wstrb = wstrb_tab[$urandom_range(0, 8)];
                ls_req_wdata = $urandom();
            end
            tick();
        end
        if (if_taken) if_req_valid = 1'b0;
        if (ls_taken) ls_req_valid = 1'b0;
        n = 0;
        while ((if_req_valid || ls_req_valid || busy) && n < 80) begin
            tick();
            if (if_taken) if_req_valid = 1'b0;
            if (ls_taken) ls_req_valid = 1'b0;
            n++;
        end
        repeat (3) tick();
        chk("drain_busy", busy, 1'b0);
        chk("drain_txn_q", txn_q.size(), 0);
        chk("drain_rsp_q", rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
